// File: rtl/ahci_dma_rd_stuff_ctrl.sv
// Host-to-device DMA read segment sequencer: gates FIFO dwords into the word
// stuffer with per-dword word masks, flushes the tail and counts packed output.
module ahci_dma_rd_stuff_ctrl #(
   parameter int WORDS_W = 22
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WORDS_W-1:0] xfer_words,
   input  logic               start_word,
   input  logic               abort,
   input  logic               fifo_av,
   input  logic               fifo_avm,
   output logic               fifo_re,
   output logic               st_din_av,
   output logic               st_din_avm,
   output logic [1:0]         st_dm,
   output logic               st_flush,
   output logic               st_rst,
   input  logic               st_din_re,
   input  logic               st_dout_vld,
   input  logic               st_dout_re,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic               overrun,
   output logic [WORDS_W-1:0] out_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_XFER, S_FLUSH, S_DRAIN, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [WORDS_W-1:0] rem;
   logic [WORDS_W-1:0] exp_cnt;
   logic [WORDS_W-1:0] exp_init;
   logic [WORDS_W-1:0] rem_left;
   logic [WORDS_W-1:0] out_cnt_nxt;
   logic [1:0]         nw;
   logic               first;
   logic               eq_r;
   logic               start_ok;
   logic               abort_ok;
   logic               out_rd;
   logic               at_exp;
   logic               cnt_inc;

   // (n+1)>>1 written as (n>>1)+lsb so it never needs a carry bit
   assign exp_init    = {1'b0, xfer_words[WORDS_W-1:1]} + WORDS_W'(xfer_words[0]);
   assign start_ok    = start && (state == S_IDLE);
   assign abort_ok    = abort && (state != S_IDLE);
   assign out_rd      = st_dout_vld && st_dout_re && (state != S_IDLE);
   assign at_exp      = (out_cnt == exp_cnt);
   assign cnt_inc     = out_rd && !at_exp;
   assign out_cnt_nxt = out_cnt + WORDS_W'(cnt_inc);
   assign nw          = {1'b0, st_dm[1]} + {1'b0, st_dm[0]};
   assign rem_left    = rem - WORDS_W'(nw);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next state; abort overrides every transition once a segment is running
   always_comb begin
      state_nxt = state;
      if (abort_ok) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start) state_nxt = (xfer_words == '0) ? S_DONE : S_XFER;
            S_XFER:  if (fifo_re && (rem_left == '0)) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_DRAIN;
            S_DRAIN: if (eq_r) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // outputs
   always_comb begin
      st_dm = 2'b11;
      if (first)                     st_dm = 2'b10;
      else if (rem == WORDS_W'(1))   st_dm = 2'b01;
      busy       = (state != S_IDLE);
      done       = (state == S_DONE);
      st_flush   = (state == S_FLUSH);
      st_din_av  = fifo_av && (state == S_XFER) && (rem != '0);
      // hide the lookahead dword when it belongs to the next segment
      st_din_avm = fifo_avm && (state == S_XFER) && (rem_left != '0);
      fifo_re    = st_din_re && st_din_av && !abort_ok;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem     <= '0;
         exp_cnt <= '0;
         first   <= 1'b0;
         out_cnt <= '0;
         overrun <= 1'b0;
         eq_r    <= 1'b0;
         aborted <= 1'b0;
         st_rst  <= 1'b0;
      end else begin
         aborted <= abort_ok;
         st_rst  <= abort_ok;
         if (start_ok) begin
            rem     <= xfer_words;
            exp_cnt <= exp_init;
            first   <= start_word;
            out_cnt <= '0;
            overrun <= 1'b0;
            eq_r    <= 1'b0;
         end else begin
            if (abort_ok) begin
               rem <= '0;
            end else if (fifo_re) begin
               rem   <= rem_left;
               first <= 1'b0;
            end
            out_cnt <= out_cnt_nxt;
            // compare against the post-update count so done lands 2 cycles after the last read
            eq_r    <= (out_cnt_nxt == exp_cnt);
            if (out_rd && at_exp) overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ahci_dma_rd_stuff_ctrl.sv
// Directed bench for ahci_dma_rd_stuff_ctrl with a FIFO / word-stuffer model
// and a queue of expected word masks popped on every FIFO read.
module tb_ahci_dma_rd_stuff_ctrl;
   localparam int WORDS_W = 22;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic [WORDS_W-1:0] xfer_words = '0;
   logic               start_word = 1'b0;
   logic               abort = 1'b0;
   logic               fifo_av, fifo_avm, fifo_re;
   logic               st_din_av, st_din_avm, st_flush, st_rst;
   logic [1:0]         st_dm;
   logic               st_din_re = 1'b1;
   logic               st_dout_vld, st_dout_re;
   logic               busy, done, aborted, overrun;
   logic [WORDS_W-1:0] out_cnt;

   int  n_assert = 0, n_fail = 0;
   int  fifo_cnt = 0, held = 0, pend = 0;
   bit  inj = 0, inj_arm = 0, cons_rdy = 1;
   int  n_re = 0, n_fl = 0, n_done = 0, n_busy = 0;
   bit  s_re, s_avm, s_fl, s_rd, s_done, s_busy, s_abt, s_srst;
   logic [1:0] s_dm;
   logic [1:0] dm_q[$];
   bit         avm_log[$];

   assign fifo_av     = (fifo_cnt >= 1);
   assign fifo_avm    = (fifo_cnt > 1);
   assign st_dout_vld = (pend > 0) || inj;
   assign st_dout_re  = cons_rdy;

   always #5 clk = ~clk;

   ahci_dma_rd_stuff_ctrl #(.WORDS_W(WORDS_W)) dut (
      .clk(clk), .rst(rst), .start(start), .xfer_words(xfer_words),
      .start_word(start_word), .abort(abort), .fifo_av(fifo_av),
      .fifo_avm(fifo_avm), .fifo_re(fifo_re), .st_din_av(st_din_av),
      .st_din_avm(st_din_avm), .st_dm(st_dm), .st_flush(st_flush),
      .st_rst(st_rst), .st_din_re(st_din_re), .st_dout_vld(st_dout_vld),
      .st_dout_re(st_dout_re), .busy(busy), .done(done), .aborted(aborted),
      .overrun(overrun), .out_cnt(out_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // one clock: sample at negedge, then advance the FIFO / stuffer model after the edge
   task automatic step();
      logic [1:0] e;
      @(negedge clk);
      s_re = fifo_re; s_dm = st_dm; s_avm = st_din_avm; s_fl = st_flush;
      s_rd = st_dout_vld && st_dout_re; s_done = done; s_busy = busy;
      s_abt = aborted; s_srst = st_rst;
      if (s_re) begin
         n_re++;
         avm_log.push_back(s_avm);
         chk("dm_expected_read", 32'(dm_q.size() != 0), 1);
         if (dm_q.size() != 0) begin
            e = dm_q.pop_front();
            chk("st_dm", 32'(s_dm), 32'(e));
         end
      end
      if (s_fl)   n_fl++;
      if (s_done) n_done++;
      if (s_busy) n_busy++;
      @(posedge clk); #1;
      if (s_srst) begin held = 0; pend = 0; end
      if (s_rd) begin
         if (pend > 0) pend--;
         else inj = 0;
      end
      if (s_re) begin
         fifo_cnt--;
         held += int'(s_dm[1]) + int'(s_dm[0]);
      end
      while (held >= 2) begin held -= 2; pend++; end
      if (s_fl && held > 0) begin held = 0; pend++; end
      if (inj_arm && s_rd && pend == 0) begin inj = 1; inj_arm = 0; end
   endtask

   task automatic start_seg(input int words, input bit sw);
      xfer_words = WORDS_W'(words);
      start_word = sw;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      int d0;
      d0 = n_done;
      for (int i = 0; i < max && n_done == d0; i++) step();
      chk(tag, 32'(n_done - d0), 1);
   endtask

   task automatic clr();
      n_re = 0; n_fl = 0; n_busy = 0;
      avm_log.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int b0, d0;
      // reset state
      #2 rst = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_out_cnt", 32'(out_cnt), 0);
      chk("rst_flush", 32'(st_flush), 0);
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;

      // 8 words aligned, 4 dwords
      clr(); fifo_cnt = 4;
      repeat (4) dm_q.push_back(2'b11);
      start_seg(8, 0);
      wait_done("t1_done", 30);
      chk("t1_fifo_re", 32'(n_re), 4);
      chk("t1_flush", 32'(n_fl), 1);
      chk("t1_out_cnt", 32'(out_cnt), 4);
      chk("t1_dm_left", 32'(dm_q.size()), 0);

      // 5 words, high word start; a 4th dword of the next segment sits in the FIFO
      clr(); fifo_cnt = 4;
      dm_q.push_back(2'b10); dm_q.push_back(2'b11); dm_q.push_back(2'b11);
      start_seg(5, 1);
      wait_done("t2_done", 30);
      chk("t2_fifo_re", 32'(n_re), 3);
      chk("t2_out_cnt", 32'(out_cnt), 3);
      chk("t2_fifo_left", 32'(fifo_cnt), 1);
      chk("t2_avm_first", 32'(avm_log.size() > 0 ? avm_log[0] : 1'b0), 1);
      chk("t2_avm_last", 32'(avm_log.size() > 2 ? avm_log[2] : 1'b1), 0);
      fifo_cnt = 0;

      // 3 words: tail word released by flush
      clr(); fifo_cnt = 2;
      dm_q.push_back(2'b11); dm_q.push_back(2'b01);
      start_seg(3, 0);
      wait_done("t3_done", 30);
      chk("t3_flush", 32'(n_fl), 1);
      chk("t3_out_cnt", 32'(out_cnt), 2);

      // zero length; a start during the done cycle is ignored
      clr();
      start_seg(0, 0);
      xfer_words = WORDS_W'(2); start = 1'b1;
      step();
      start = 1'b0;
      chk("t4_done_lat", 32'(s_done), 1);
      repeat (3) step();
      chk("t4_busy_cycles", 32'(n_busy), 1);
      chk("t4_fifo_re", 32'(n_re), 0);
      chk("t4_flush", 32'(n_fl), 0);

      // abort after 2 of 6 dwords
      clr(); fifo_cnt = 6;
      repeat (6) dm_q.push_back(2'b11);
      d0 = n_done;
      start_seg(12, 0);
      step(); step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t5_abort_fifo_re", 32'(s_re), 0);
      step();
      chk("t5_aborted", 32'(s_abt), 1);
      chk("t5_st_rst", 32'(s_srst), 1);
      chk("t5_idle", 32'(s_busy), 0);
      step();
      chk("t5_aborted_pulse", 32'(s_abt), 0);
      chk("t5_fifo_re", 32'(n_re), 2);
      chk("t5_no_done", 32'(n_done - d0), 0);
      dm_q.delete(); fifo_cnt = 0;
      abort = 1'b1; step(); abort = 1'b0; step();
      chk("t5_idle_abort", 32'(s_abt), 0);
      clr(); fifo_cnt = 1; dm_q.push_back(2'b11);
      start_seg(2, 0);
      wait_done("t5_restart_done", 30);
      chk("t5_restart_out", 32'(out_cnt), 1);

      // extra stuffer output once the expected count is reached
      clr(); fifo_cnt = 2; inj_arm = 1;
      dm_q.push_back(2'b11); dm_q.push_back(2'b11);
      start_seg(4, 0);
      wait_done("t6_done", 30);
      chk("t6_overrun", 32'(overrun), 1);
      chk("t6_out_cnt", 32'(out_cnt), 2);
      step(); step();
      chk("t6_overrun_held", 32'(overrun), 1);
      clr(); fifo_cnt = 1; dm_q.push_back(2'b11);
      start_seg(2, 0);
      chk("t6_overrun_clr", 32'(overrun), 0);
      wait_done("t6_next_done", 30);

      // async reset while stalled in DRAIN
      clr(); fifo_cnt = 3;
      repeat (3) dm_q.push_back(2'b11);
      start_seg(6, 0);
      repeat (3) step();
      cons_rdy = 0;
      repeat (3) step();
      b0 = n_busy;
      chk("t7_stalled_busy", 32'(busy), 1);
      chk("t7_stalled_cnt", 32'(out_cnt), 2);
      @(negedge clk); #2 rst = 1'b1; #1;
      chk("t7_rst_busy", 32'(busy), 0);
      chk("t7_rst_cnt", 32'(out_cnt), 0);
      chk("t7_rst_flags", 32'({done, aborted, overrun, st_flush, st_rst, fifo_re}), 0);
      @(posedge clk); #1 rst = 1'b0;
      fifo_cnt = 0; held = 0; pend = 0; inj = 0; cons_rdy = 1;
      dm_q.delete();
      step();
      chk("t7_after_rst_busy", 32'(s_busy), 0);
      b0 = b0 + 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
